id_decoder: RTL
===============

# id_decoder

Registered RV32I decode stage sitting between the instruction fetch stage and execute. It accepts instruction/PC pairs over a valid/ready handshake and decodes the supported subset (ADD, SUB, SLL, ADDI, LW, SW, BEQ) into register indices, a sign-extended immediate and control strobes. It holds the result in a one-entry ID/EX register, inserts a one-cycle bubble on a load-use hazard, and supports a synchronous flush from branch resolution.

## Interface
- `PC_W`, 32, width of the program counter carried alongside the instruction.
- `i_clk`  in  1  stage clock; all state updates on rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  fetch presents a valid `i_instr`/`i_pc`.
- `o_ready`  out  1  decode accepts the presented instruction this cycle.
- `i_instr`  in  32  raw instruction word.
- `i_pc`  in  PC_W  PC of `i_instr`.
- `i_flush`  in  1  synchronous kill of the held entry and the presented instruction.
- `o_valid`  out  1  ID/EX register holds a valid decoded instruction.
- `i_ready`  in  1  execute consumes the entry this cycle.
- `o_pc`  out  PC_W  PC of the held instruction.
- `o_op`  out  op_e  decoded operation.
- `o_rd`, `o_rs1`, `o_rs2`  out  5 each  register indices.
- `o_imm`  out  32  sign-extended immediate.
- `o_reg_we`, `o_mem_re`, `o_mem_we`, `o_branch`, `o_illegal`  out  1 each  control strobes.
- `o_stall_cnt`  out  16  number of load-use bubbles inserted; saturating.

## Operation
- Decode by opcode/funct3/funct7:
  - 0110011/000/0000000 is ADD.
  - 0110011/000/0100000 is SUB.
  - 0110011/001/0000000 is SLL.
  - 0010011/000 is ADDI.
  - 0000011/010 is LW.
  - 0100011/010 is SW.
  - 1100011/000 is BEQ.
  - Everything else (including 0x00000000) is OP_ILLEGAL, with `o_illegal`=1 and all other strobes 0.
- Immediates:
  - I-type: sext(instr[31:20]).
  - S-type: sext({instr[31:25],instr[11:7]}).
  - B-type: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - R-type: 0.
- Field forcing: for S and B, `o_rd`=0 and `o_reg_we`=0. For R and I, `o_reg_we` is 1 only when rd≠0. For I-type, `o_rs2` is forced to 0.
- Strobes: LW sets `o_mem_re`. SW sets `o_mem_we`. BEQ sets `o_branch`.
- Acceptance: `o_ready` = !i_flush && !hazard && (!o_valid || i_ready).
- Load-use hazard: asserted when all of the following hold:
  - `o_valid` is 1, `o_op`=LW, `o_rd`≠0 and `i_ready` is 1;
  - `i_valid` is 1;
  - the incoming instruction reads `o_rd` (rs1 for R/I/S/B; rs2 for R/S/B).

  On a hazard the LW moves to execute, the register loads a bubble (`o_valid`=0), the incoming instruction is not accepted, and `o_stall_cnt` increments (holding at 0xFFFF).
- Flush has priority over acceptance and hazard. On a flush, `o_valid` becomes 0 next cycle, the presented instruction is dropped, and `o_stall_cnt` does not increment.
- Illegal instructions flow through normally with `o_illegal`=1; decode does not halt.

## Timing
- Latency: an instruction accepted on edge N appears on `o_valid`/fields after edge N.
- Throughput: one instruction per cycle when `i_ready` is held 1 and there are no hazards.
- Backpressure: while `o_valid` && !i_ready, all outputs hold stable and `o_ready`=0.
- Empty register: `o_ready`=1 regardless of `i_ready` (unless flush or hazard).
- Reset (asynchronous, any time, including mid-stall):
  - `o_valid`=0;
  - `o_op`=OP_ILLEGAL, with `o_illegal`=0;
  - all indices, `o_imm`, `o_pc` and strobes = 0;
  - `o_stall_cnt`=0.

  The first accept is possible on the first edge after deassertion.
- Field contents when `o_valid`=0 are don't-care except immediately after reset.

## Structure
- Package `id_pkg` holds:
  - `op_e` enum: OP_ADD, OP_SUB, OP_SLL, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_ILLEGAL;
  - opcode, funct3 and funct7 localparams;
  - packed struct `id_ctrl_t` containing op, rd, rs1, rs2, imm and the five strobes.
- Sub-module `id_decode_comb` is the pure combinational instruction-to-`id_ctrl_t` decoder including immediate generation.
- `id_decoder` owns the ID/EX register, handshake, hazard check, flush and counter.

## Test plan
- Reset, then 0x00108093 (ADDI x1,x1,1) → next cycle `o_valid`=1, OP_ADDI, rd=1, rs1=1, imm=1, reg_we=1.
- 0xFE0086E3 (BEQ x1,x0,-20) → OP_BEQ, rs1=1, rs2=0, imm=0xFFFFFFEC, branch=1, rd=0, reg_we=0.
- 0x00902223 (SW x9,4(x0)), then 0x408484B3 (SUB x9,x9,x8) → SW: imm=4, rs2=9, mem_we=1; SUB: rd=9, rs1=9, rs2=8.
- 0x00402503 (LW x10,4(x0)), then 0x000505B3 (ADD x11,x10,x0) with `i_ready`=1 → one bubble cycle with `o_ready`=0; ADD is issued the cycle after; `o_stall_cnt`=1.
- `i_ready`=0 for 3 cycles with an entry held → outputs stable and `o_ready`=0. Then assert `i_flush` → `o_valid`=0 next cycle and the presented instruction never appears.
- 0x00000000 and 0x0000707F → `o_illegal`=1 and all strobes 0. Assert `i_rst_n`=0 mid-stream → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/id_pkg.sv
// id_pkg: shared types and encodings for the RV32I decode stage.
//   op_e       decoded operation (subset: ADD SUB SLL ADDI LW SW BEQ)
//   id_ctrl_t  decoded control word held in the ID/EX register
//   reads_rs1/reads_rs2  which source registers an operation consumes
package id_pkg;

  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_SLL     = 3'd2,
    OP_ADDI    = 3'd3,
    OP_LW      = 3'd4,
    OP_SW      = 3'd5,
    OP_BEQ     = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        branch;
    logic        illegal;
  } id_ctrl_t;

  // Reset content of the ID/EX register: op reads ILLEGAL but the illegal
  // strobe itself stays low so nothing downstream traps on an empty stage.
  localparam id_ctrl_t CTRL_RST = '{
    op: OP_ILLEGAL, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, imm: 32'd0,
    reg_we: 1'b0, mem_re: 1'b0, mem_we: 1'b0, branch: 1'b0, illegal: 1'b0
  };

  function automatic logic reads_rs1(input op_e op);
    return (op != OP_ILLEGAL);
  endfunction

  function automatic logic reads_rs2(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLL) ||
           (op == OP_SW)  || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/id_decode_comb.sv
// id_decode_comb: purely combinational RV32I-subset decoder.
//   instr  in   32-bit raw instruction word
//   ctrl   out  decoded id_ctrl_t (op, indices, sign-extended imm, strobes)
module id_decode_comb
  import id_pkg::*;
(
  input  logic [31:0] instr,
  output id_ctrl_t    ctrl
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  op_e         op;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  always_comb begin
    op = OP_ILLEGAL;
    unique case (opcode)
      OPC_OP: begin
        if (funct3 == F3_ADD_SUB && funct7 == F7_BASE)     op = OP_ADD;
        else if (funct3 == F3_ADD_SUB && funct7 == F7_SUB) op = OP_SUB;
        else if (funct3 == F3_SLL && funct7 == F7_BASE)    op = OP_SLL;
      end
      OPC_OP_IMM: if (funct3 == F3_ADDI) op = OP_ADDI;
      OPC_LOAD:   if (funct3 == F3_LW)   op = OP_LW;
      OPC_STORE:  if (funct3 == F3_SW)   op = OP_SW;
      OPC_BRANCH: if (funct3 == F3_BEQ)  op = OP_BEQ;
      default:    op = OP_ILLEGAL;
    endcase
  end

  always_comb begin
    ctrl    = CTRL_RST;
    ctrl.op = op;
    unique case (op)
      OP_ADD, OP_SUB, OP_SLL: begin
        ctrl.rd     = rd;
        ctrl.rs1    = rs1;
        ctrl.rs2    = rs2;
        ctrl.reg_we = (rd != 5'd0);
      end
      OP_ADDI, OP_LW: begin
        ctrl.rd     = rd;
        ctrl.rs1    = rs1;
        ctrl.imm    = imm_i;
        ctrl.reg_we = (rd != 5'd0);
        ctrl.mem_re = (op == OP_LW);
      end
      OP_SW: begin
        ctrl.rs1    = rs1;
        ctrl.rs2    = rs2;
        ctrl.imm    = imm_s;
        ctrl.mem_we = 1'b1;
      end
      OP_BEQ: begin
        ctrl.rs1    = rs1;
        ctrl.rs2    = rs2;
        ctrl.imm    = imm_b;
        ctrl.branch = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_decoder.sv
// id_decoder: registered decode stage with a one-entry ID/EX register.
//   i_clk/i_rst_n            clock, async active-low reset
//   i_valid/o_ready          fetch handshake carrying i_instr/i_pc
//   i_flush                  kills held entry and presented instruction
//   o_valid/i_ready          execute handshake for the held entry
//   o_pc, o_op, o_rd/rs1/rs2, o_imm, strobes   held decoded instruction
//   o_stall_cnt              saturating count of load-use bubbles
module id_decoder
  import id_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [PC_W-1:0] o_pc,
  output op_e             o_op,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [31:0]     o_imm,
  output logic            o_reg_we,
  output logic            o_mem_re,
  output logic            o_mem_we,
  output logic            o_branch,
  output logic            o_illegal,
  output logic [15:0]     o_stall_cnt
);

  id_ctrl_t        dec;
  id_ctrl_t        ctrl_q;
  logic            valid_q;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     stall_q;
  logic            hazard;
  logic            src_hit;
  logic            accept;

  id_decode_comb u_dec (
    .instr (i_instr),
    .ctrl  (dec)
  );

  // Incoming instruction needs the value the held LW has not loaded yet.
  assign src_hit = (reads_rs1(dec.op) && dec.rs1 == ctrl_q.rd) ||
                   (reads_rs2(dec.op) && dec.rs2 == ctrl_q.rd);

  assign hazard = valid_q && ctrl_q.op == OP_LW && ctrl_q.rd != 5'd0 &&
                  i_ready && i_valid && src_hit;

  assign o_ready = !i_flush && !hazard && (!valid_q || i_ready);
  assign accept  = o_ready && i_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_RST;
      pc_q    <= '0;
      stall_q <= 16'd0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      ctrl_q  <= dec;
      pc_q    <= i_pc;
    end else if (hazard) begin
      valid_q <= 1'b0;
      if (stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end else if (valid_q && i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_valid     = valid_q;
  assign o_pc        = pc_q;
  assign o_op        = ctrl_q.op;
  assign o_rd        = ctrl_q.rd;
  assign o_rs1       = ctrl_q.rs1;
  assign o_rs2       = ctrl_q.rs2;
  assign o_imm       = ctrl_q.imm;
  assign o_reg_we    = ctrl_q.reg_we;
  assign o_mem_re    = ctrl_q.mem_re;
  assign o_mem_we    = ctrl_q.mem_we;
  assign o_branch    = ctrl_q.branch;
  assign o_illegal   = ctrl_q.illegal;
  assign o_stall_cnt = stall_q;

endmodule
